// File: rtl/control_sequencer.sv
// control_sequencer
//   Sequences one instruction at a time through fetch, an optional data
//   memory access, a single execute cycle and a trap state. It takes decoded
//   flags from the instruction decoders and drives pc_inc, reg_we and the data
//   memory request for the datapath/MMU. The trap cause and the
//   retired-instruction count are kept in registers.
//
// Parameters
//   MEM_TIMEOUT  most cycles to wait for mem_ready before a timeout trap
//   TO_W         width of the memory-wait counter
//   CNT_W        width of retired_count
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   go, halt_req          start/acknowledge; stop after the current retire
//   instr_req/ready/segv  fetch handshake and fetch fault
//   dec_ld/st/wb/invalid  decoded flags, valid with instr_ready
//   mem_req/we/ready      data handshake; mem_we = 1 for a store
//   data_segv             data fault, valid with mem_ready
//   pc_inc, reg_we        execute pulses
//   busy, trap            status flags
//   trap_cause            0 none, 1 instr_segv, 2 data_segv, 3 invalid,
//                         4 memory timeout
//   retired_count         instructions retired since reset, wraps
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             halt_req,
  output logic             instr_req,
  input  logic             instr_ready,
  input  logic             instr_segv,
  input  logic             dec_ld,
  input  logic             dec_st,
  input  logic             dec_wb,
  input  logic             dec_invalid,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic             data_segv,
  output logic             pc_inc,
  output logic             reg_we,
  output logic             busy,
  output logic             trap,
  output logic [2:0]       trap_cause,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_MEM,
    S_EXEC,
    S_TRAP
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_ISEGV   = 3'd1;
  localparam logic [2:0] CAUSE_DSEGV   = 3'd2;
  localparam logic [2:0] CAUSE_INVALID = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  state_t           state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic             wb_q, wb_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_HALT;
      mem_we_q  <= 1'b0;
      wb_q      <= 1'b0;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_we_q  <= mem_we_d;
      wb_q      <= wb_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_we_d  = mem_we_q;
    wb_d      = wb_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    retired_d = retired_q;

    unique case (state_q)
      S_HALT: begin
        if (go) state_d = S_FETCH;
      end

      // Fault priority: a fetch fault wins over anything the decoder
      // reports, and a load and store in the same instruction counts as
      // an invalid encoding.
      S_FETCH: begin
        if (instr_ready) begin
          if (instr_segv) begin
            state_d = S_TRAP;
            cause_d = CAUSE_ISEGV;
          end else if (dec_invalid || (dec_ld && dec_st)) begin
            state_d = S_TRAP;
            cause_d = CAUSE_INVALID;
          end else if (dec_ld || dec_st) begin
            state_d  = S_MEM;
            mem_we_d = dec_st;
            wb_d     = dec_ld | dec_wb;
            wait_d   = '0;
          end else begin
            state_d = S_EXEC;
            wb_d    = dec_wb;
          end
        end
      end

      // The counter shows 0 in the first MEM cycle. A response in the
      // cycle the counter equals MEM_TIMEOUT is still accepted. The
      // timeout trap fires only when that last cycle also passes with
      // no response.
      S_MEM: begin
        if (mem_ready) begin
          if (data_segv) begin
            state_d = S_TRAP;
            cause_d = CAUSE_DSEGV;
          end else begin
            state_d = S_EXEC;
          end
        end else if (wait_q == TIMEOUT_VAL) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end

      // halt_req is looked at only here, so an instruction that is
      // already in flight always finishes.
      S_EXEC: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = halt_req ? S_HALT : S_FETCH;
      end

      S_TRAP: begin
        if (go) begin
          state_d = S_HALT;
          cause_d = CAUSE_NONE;
        end
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // All outputs are decoded from registered state. The bus requests
  // therefore drop as soon as reset is asserted, without waiting for a
  // clock edge.
  assign instr_req     = (state_q == S_FETCH);
  assign mem_req       = (state_q == S_MEM);
  assign mem_we        = (state_q == S_MEM) && mem_we_q;
  assign pc_inc        = (state_q == S_EXEC);
  assign reg_we        = (state_q == S_EXEC) && wb_q;
  assign busy          = (state_q != S_HALT) && (state_q != S_TRAP);
  assign trap          = (state_q == S_TRAP);
  assign trap_cause    = cause_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed and random instruction sequences for control_sequencer. The
//   bench plays the fetch and memory side of the bus. For each instruction
//   it works out the outcome (trap cause, writeback, store flag, cycles spent
//   in the memory wait, retire count) from the instruction-level rules. It
//   then checks the DUT cycle by cycle against that outcome.
module tb_control_sequencer;

  localparam int CNT_W       = 4;
  localparam int TO_W        = 4;
  localparam int MEM_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             go, halt_req;
  logic             instr_req, instr_ready, instr_segv;
  logic             dec_ld, dec_st, dec_wb, dec_invalid;
  logic             mem_req, mem_we, mem_ready, data_segv;
  logic             pc_inc, reg_we, busy, trap;
  logic [2:0]       trap_cause;
  logic [CNT_W-1:0] retired_count;

  int compared   = 0;
  int mismatched = 0;
  int modelRetired = 0;
  bit running = 1'b0;

  control_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .halt_req     (halt_req),
    .instr_req    (instr_req),
    .instr_ready  (instr_ready),
    .instr_segv   (instr_segv),
    .dec_ld       (dec_ld),
    .dec_st       (dec_st),
    .dec_wb       (dec_wb),
    .dec_invalid  (dec_invalid),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .data_segv    (data_segv),
    .pc_inc       (pc_inc),
    .reg_we       (reg_we),
    .busy         (busy),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a miss with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic stepCycle();
    @(negedge clk);
  endtask

  task automatic scrambleDecode();
    instr_segv  = 1'($urandom_range(0, 1));
    dec_ld      = 1'($urandom_range(0, 1));
    dec_st      = 1'($urandom_range(0, 1));
    dec_wb      = 1'($urandom_range(0, 1));
    dec_invalid = 1'($urandom_range(0, 1));
  endtask

  // Runs one instruction end to end. fDelay idle cycles come before
  // instr_ready. mDelay is the wait index at which mem_ready arrives; a
  // value above MEM_TIMEOUT means no response. On a trap the task
  // acknowledges it with go, which leaves the DUT in HALT.
  task automatic applyStimulus(input int fDelay, input bit iSegv, input bit dInv,
                               input bit dLd, input bit dSt, input bit dWb,
                               input int mDelay, input bit dSegv, input bit haltReq);
    int cause;
    bit isMem, willWb, done;
    if (!running) begin
      checkOutput("halt_busy", 32'(busy), 32'd0);
      go = 1'b1;
      halt_req = 1'($urandom_range(0, 1));
      stepCycle();
      go = 1'b0;
      running = 1'b1;
    end
    for (int i = 0; i < fDelay; i++) begin
      checkOutput("fetch_req", 32'(instr_req), 32'd1);
      checkOutput("fetch_busy", 32'(busy), 32'd1);
      instr_ready = 1'b0;
      halt_req = 1'($urandom_range(0, 1));
      scrambleDecode();
      stepCycle();
    end
    checkOutput("fetch_req", 32'(instr_req), 32'd1);
    instr_ready = 1'b1;
    instr_segv  = iSegv;
    dec_invalid = dInv;
    dec_ld      = dLd;
    dec_st      = dSt;
    dec_wb      = dWb;
    halt_req    = 1'($urandom_range(0, 1));
    stepCycle();
    instr_ready = 1'b0;
    scrambleDecode();

    cause  = iSegv ? 1 : ((dInv || (dLd && dSt)) ? 3 : 0);
    isMem  = dLd || dSt;
    willWb = isMem ? (dLd || dWb) : dWb;

    if (cause == 0 && isMem) begin
      done = 1'b0;
      for (int k = 0; k <= MEM_TIMEOUT && !done; k++) begin
        checkOutput("mem_req", 32'(mem_req), 32'd1);
        checkOutput("mem_we", 32'(mem_we), 32'(dSt));
        checkOutput("mem_no_pc_inc", 32'(pc_inc), 32'd0);
        mem_ready = (k == mDelay);
        data_segv = mem_ready ? dSegv : 1'($urandom_range(0, 1));
        halt_req  = 1'($urandom_range(0, 1));
        stepCycle();
        if (k == mDelay) done = 1'b1;
      end
      mem_ready = 1'b0;
      data_segv = 1'b0;
      if (!done) cause = 4;
      else if (dSegv) cause = 2;
    end

    if (cause != 0) begin
      halt_req = 1'b0;
      checkOutput("trap", 32'(trap), 32'd1);
      checkOutput("trap_cause", 32'(trap_cause), 32'(cause));
      checkOutput("trap_pc_inc", 32'(pc_inc), 32'd0);
      checkOutput("trap_reg_we", 32'(reg_we), 32'd0);
      checkOutput("trap_busy", 32'(busy), 32'd0);
      stepCycle();
      checkOutput("trap_hold_cause", 32'(trap_cause), 32'(cause));
      go = 1'b1;
      stepCycle();
      go = 1'b0;
      checkOutput("trap_exit", 32'(trap), 32'd0);
      checkOutput("trap_cleared_cause", 32'(trap_cause), 32'd0);
      checkOutput("trap_halt_busy", 32'(busy), 32'd0);
      checkOutput("retired_after_trap", 32'(retired_count), 32'(modelRetired));
      running = 1'b0;
    end else begin
      checkOutput("exec_pc_inc", 32'(pc_inc), 32'd1);
      checkOutput("exec_reg_we", 32'(reg_we), 32'(willWb));
      checkOutput("exec_no_mem_req", 32'(mem_req), 32'd0);
      halt_req = haltReq;
      stepCycle();
      halt_req = 1'b0;
      modelRetired = (modelRetired + 1) % (1 << CNT_W);
      checkOutput("retired", 32'(retired_count), 32'(modelRetired));
      checkOutput("pc_inc_single", 32'(pc_inc), 32'd0);
      if (haltReq) begin
        checkOutput("halted_busy", 32'(busy), 32'd0);
        running = 1'b0;
      end else begin
        checkOutput("next_fetch", 32'(instr_req), 32'd1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    go = 1'b0; halt_req = 1'b0;
    instr_ready = 1'b0; instr_segv = 1'b0;
    dec_ld = 1'b0; dec_st = 1'b0; dec_wb = 1'b0; dec_invalid = 1'b0;
    mem_ready = 1'b0; data_segv = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset_instr_req", 32'(instr_req), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_pc_inc", 32'(pc_inc), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_trap", 32'(trap), 32'd0);
    checkOutput("reset_cause", 32'(trap_cause), 32'd0);
    checkOutput("reset_retired", 32'(retired_count), 32'd0);
    reset = 1'b0;

    // halt_req has no effect in HALT, and without go the sequencer stays.
    halt_req = 1'b1;
    stepCycle();
    stepCycle();
    halt_req = 1'b0;
    checkOutput("halt_stays", 32'(busy), 32'd0);
    checkOutput("halt_no_fetch", 32'(instr_req), 32'd0);

    // Four writeback instructions back to back, halting after the fourth.
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, i == 3);
    checkOutput("four_retired", 32'(retired_count), 32'd4);

    // Load with ready three cycles late; store with immediate ready.
    applyStimulus(1, 0, 0, 1, 0, 0, 3, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    // No mem_ready at all: timeout trap.
    applyStimulus(0, 0, 0, 1, 0, 0, 99, 0, 0);
    // Fetch fault outranks invalid; load+store is invalid; data fault.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 2, 1, 0);
    // Response on the last allowed wait cycle still completes.
    applyStimulus(0, 0, 0, 0, 1, 1, MEM_TIMEOUT, 0, 1);

    // Reset in the middle of a memory wait drops mem_req at once.
    go = 1'b1;
    stepCycle();
    go = 1'b0;
    instr_ready = 1'b1; dec_ld = 1'b1; dec_st = 1'b0; dec_invalid = 1'b0; instr_segv = 1'b0;
    stepCycle();
    instr_ready = 1'b0;
    checkOutput("pre_reset_mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_retired", 32'(retired_count), 32'd0);
    stepCycle();
    reset = 1'b0;
    modelRetired = 0;
    running = 1'b0;

    // Seventeen retires wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, i == 16);
    checkOutput("retired_wrap", 32'(retired_count), 32'd1);

    // Random instruction mix.
    for (int n = 0; n < 40; n++)
      applyStimulus($urandom_range(0, 3),
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, MEM_TIMEOUT + 2),
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
